// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised synchronous FIFO.
// Latency: none, compile-time only.
// Backpressure: not applicable; it holds no logic.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Depth must be a power of two so that pointers wrap naturally.
    // Both thresholds must leave a distinct almost_empty and almost_full band.
    function automatic bit levels_ok(input int ae, input int af, input int depth);
        return (depth >= 2) && ((1 << clog2(depth)) == depth) &&
               (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bus of the synchronous FIFO: push, pop, flush, data, flags, error pulses.
// Latency: wires only.
// Backpressure: producer watches full/almost_full, consumer watches empty/almost_empty.
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = clog2(DEPTH);

    logic             flush;
    logic             write;
    logic [WIDTH-1:0] din;
    logic             read;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, write, din, read,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, write, din, read,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH register file with one synchronous write port and one asynchronous read port.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; the caller decides when writes are legal.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, flush and overflow/underflow pulses.
// Latency: dout one cycle after a pop; FIFO_FWFT_EN gives fall-through with zero read latency.
// Backpressure: writes on full are rejected unless a pop happens in the same cycle.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic             clk,
    input  logic             clrn,
    fifo_sync_param_if.slave bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    generate
        if (!levels_ok(AE_LEVEL, AF_LEVEL, DEPTH)) begin : g_bad_cfg
            $error("fifo_sync_param: need power-of-two DEPTH and AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             ovf_q;
    logic             udf_q;
    logic             empty;
    logic             full;
    logic             rd_ok;
    logic             wr_ok;
    logic [WIDTH-1:0] rdata;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_C);

    // A pop frees a slot in the same edge, so a full FIFO can still take a write.
    assign rd_ok = bus.read & ~empty;
    assign wr_ok = bus.write & (~full | rd_ok);

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok & ~bus.flush),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            ovf_q <= bus.write & ~wr_ok;
            udf_q <= bus.read & ~rd_ok;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.dout = empty ? '0 : rdata;
`else
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dout_q <= '0;
        end else if (!bus.flush && rd_ok) begin
            dout_q <= rdata;
        end
    end

    assign bus.dout = dout_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (WIDTH=8, DEPTH=4, default thresholds).
// Table rows carry expected count/error pulses; a queue scoreboard supplies expected dout.
module tb_fifo_sync_param;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = D - 1;
    localparam int AE = 1;

    logic clk;
    logic clrn;

    fifo_sync_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

    fifo_sync_param #(.WIDTH(W), .DEPTH(D)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    logic [W-1:0] sb_q [$];
    logic [W-1:0] exp_dout;

    typedef struct {
        bit           fl;
        bit           wr;
        logic [W-1:0] din;
        bit           rd;
        int           cnt;
        bit           ovf;
        bit           udf;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string nm, input int cnt, input bit ovf, input bit udf);
        chk({nm, ".count"},        32'(bus.count), 32'(cnt));
        chk({nm, ".full"},         32'(bus.full), 32'(cnt == D));
        chk({nm, ".empty"},        32'(bus.empty), 32'(cnt == 0));
        chk({nm, ".almost_full"},  32'(bus.almost_full), 32'(cnt >= AF));
        chk({nm, ".almost_empty"}, 32'(bus.almost_empty), 32'(cnt <= AE));
        chk({nm, ".overflow"},     32'(bus.overflow), 32'(ovf));
        chk({nm, ".underflow"},    32'(bus.underflow), 32'(udf));
        chk({nm, ".dout"},         32'(bus.dout), 32'(exp_dout));
    endtask

    // One clock: drive on the falling edge, update the scoreboard, sample 1ns after the rising edge.
    task automatic step(input bit fl, input bit wr, input logic [W-1:0] d, input bit rd,
                        input int cnt, input bit ovf, input bit udf, input string nm);
        bit rd_acc;
        bit wr_acc;
        @(negedge clk);
        bus.flush = fl;
        bus.write = wr;
        bus.din   = d;
        bus.read  = rd;
        rd_acc = !fl && rd && (sb_q.size() > 0);
        wr_acc = !fl && wr && ((sb_q.size() < D) || rd_acc);
        if (fl) begin
            sb_q.delete();
        end else begin
            if (rd_acc) begin
`ifndef FIFO_FWFT_EN
                exp_dout = sb_q[0];
`endif
                void'(sb_q.pop_front());
            end
            if (wr_acc) sb_q.push_back(d);
        end
`ifdef FIFO_FWFT_EN
        exp_dout = (sb_q.size() > 0) ? sb_q[0] : '0;
`endif
        @(posedge clk);
        #1;
        check_outputs(nm, cnt, ovf, udf);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_dout = '0;

        //            fl  wr  din    rd  cnt ovf udf
        tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h44, 1'b0, 4, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h55, 1'b0, 4, 1'b1, 1'b0};  // write on full
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4, 1'b0, 1'b0};  // pulse gone
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1};  // read on empty
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h66, 1'b1, 1, 1'b0, 1'b1};  // rd+wr on empty
        tbl[13] = '{1'b0, 1'b1, 8'h77, 1'b0, 2, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 8'h88, 1'b0, 3, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 8'h99, 1'b0, 4, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 8'hAA, 1'b1, 4, 1'b0, 1'b0};  // rd+wr on full
        tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 8'hBB, 1'b0, 0, 1'b0, 1'b0};  // flush beats write
        tbl[19] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0};  // flush hides underflow

        bus.flush = 1'b0;
        bus.write = 1'b0;
        bus.din   = '0;
        bus.read  = 1'b0;
        clrn      = 1'b0;

        #3;
        check_outputs("reset", 0, 1'b0, 1'b0);
        @(negedge clk);
        clrn = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, "idle");

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].fl, tbl[i].wr, tbl[i].din, tbl[i].rd,
                 tbl[i].cnt, tbl[i].ovf, tbl[i].udf, $sformatf("row%0d", i));
        end

        // Interleaved pairs walk both pointers around the ring more than twice.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'(i * 8'h13 + 8'h01), 1'b0, 1, 1'b0, 1'b0, $sformatf("wrap_w%0d", i));
            step(1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, $sformatf("wrap_r%0d", i));
        end

        // Fill, provoke an overflow pulse, then reset between edges.
        step(1'b0, 1'b1, 8'hC1, 1'b0, 1, 1'b0, 1'b0, "pre_rst1");
        step(1'b0, 1'b1, 8'hC2, 1'b0, 2, 1'b0, 1'b0, "pre_rst2");
        step(1'b0, 1'b1, 8'hC3, 1'b0, 3, 1'b0, 1'b0, "pre_rst3");
        step(1'b0, 1'b1, 8'hC4, 1'b0, 4, 1'b0, 1'b0, "pre_rst4");
        step(1'b0, 1'b1, 8'hC5, 1'b0, 4, 1'b1, 1'b0, "pre_rst_ovf");
        #2;
        clrn = 1'b0;
        sb_q.delete();
        exp_dout = '0;
        #1;
        check_outputs("async_rst", 0, 1'b0, 1'b0);
        @(negedge clk);
        bus.write = 1'b0;
        clrn = 1'b1;

        // Single word into an empty FIFO: visible only after a pop unless fall-through.
        step(1'b0, 1'b1, 8'hA5, 1'b0, 1, 1'b0, 1'b0, "a5_write");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, "a5_hold");
        step(1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, "a5_read");
        step(1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, "final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
